// File: rtl/wb_test_master.sv
// Single-transfer Wishbone B3 classic master: one start pulse runs one read or write,
// with retry handling, a no-response timeout and error reporting.
module wb_test_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RETRY_MAX = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    input  logic            start,
    input  logic [AW-1:0]   address,
    input  logic [DW/8-1:0] selection,
    input  logic            write,
    input  logic [DW-1:0]   data_wr,
    output logic [DW-1:0]   data_rd,
    output logic            active,
    output logic            error
);

    localparam int SW    = DW / 8;
    localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [TMO_W-1:0] TMO_LAST  = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : {TMO_W{1'b0}};
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RETRY = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [RTY_W-1:0]  retry_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              tmo_hit_s;
    logic              done_ok_s;
    logic              done_err_s;
    logic              go_retry_s;

    // Classic single cycles only; burst signalling is fixed.
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // Decode the bus response for the current BUS cycle; err wins over ack, ack over rty.
    always_comb begin
        tmo_hit_s  = TMO_EN && (tmo_cnt_r == TMO_LAST);
        done_ok_s  = 1'b0;
        done_err_s = 1'b0;
        go_retry_s = 1'b0;
        if (state_r == ST_BUS) begin
            if (wb_err_i) begin
                done_err_s = 1'b1;
            end else if (wb_ack_i) begin
                done_ok_s = 1'b1;
            end else if (wb_rty_i) begin
                if (retry_cnt_r < RTY_LIMIT) begin
                    go_retry_s = 1'b1;
                end else begin
                    done_err_s = 1'b1;
                end
            end else if (tmo_hit_s) begin
                done_err_s = 1'b1;
            end else begin
                done_ok_s = 1'b0;
            end
        end else begin
            done_ok_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_BUS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (done_ok_s || done_err_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (go_retry_s) begin
                    state_nxt_s = ST_RETRY;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_RETRY: state_nxt_s = ST_BUS;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Registered bus outputs, status and counters; the request is held on the bus outputs themselves.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            wb_adr_o    <= {AW{1'b0}};
            wb_dat_o    <= {DW{1'b0}};
            wb_sel_o    <= {SW{1'b0}};
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            data_rd     <= {DW{1'b0}};
            active      <= 1'b0;
            error       <= 1'b0;
            retry_cnt_r <= {RTY_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        wb_adr_o    <= address;
                        wb_dat_o    <= data_wr;
                        wb_sel_o    <= selection;
                        wb_we_o     <= write;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        active      <= 1'b1;
                        error       <= 1'b0;
                        retry_cnt_r <= {RTY_W{1'b0}};
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                    end
                end
                ST_BUS: begin
                    if (done_ok_s || done_err_s) begin
                        if (done_ok_s && !wb_we_o) begin
                            data_rd <= wb_dat_i;
                        end
                        wb_adr_o <= {AW{1'b0}};
                        wb_dat_o <= {DW{1'b0}};
                        wb_sel_o <= {SW{1'b0}};
                        wb_we_o  <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        active   <= 1'b0;
                        error    <= done_err_s;
                    end else if (go_retry_s) begin
                        wb_stb_o    <= 1'b0;
                        retry_cnt_r <= retry_cnt_r + RTY_W'(1);
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_RETRY: begin
                    wb_stb_o  <= 1'b1;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end
                default: begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    active   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_test_master.sv
// Bench for wb_test_master: scripted Wishbone slave plus a cycle-level reference model
// that predicts duration, retry gaps, error status and read data.
module tb_wb_test_master;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int RETRY_MAX = 4;
    localparam int TIMEOUT   = 64;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b0;
    logic [31:0]   wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;
    logic          start = 1'b0;
    logic [31:0]   address = 32'h0;
    logic [3:0]    selection = 4'h0;
    logic          write = 1'b0;
    logic [31:0]   data_wr = 32'h0;
    logic [31:0]   data_rd;
    logic          active;
    logic          error;

    int checks = 0;
    int failures = 0;

    // Response codes per strobed cycle: 0 none, 1 ack, 2 err, 3 rty, 4 err+ack+rty, 5 ack+rty
    int script[$];
    int resp_q[$];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] exp_rd = 32'h0;

    wb_test_master #(.AW(AW), .DW(DW), .RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .start(start), .address(address), .selection(selection), .write(write),
        .data_wr(data_wr), .data_rd(data_rd), .active(active), .error(error)
    );

    always #5 wb_clk = ~wb_clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    // Slave BFM: consumes one scripted response per strobed cycle, half a cycle before the master samples.
    always @(negedge wb_clk) begin
        int r;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0;
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
            r = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
            wb_ack_i = (r == 1) || (r == 4) || (r == 5);
            wb_err_i = (r == 2) || (r == 4);
            wb_rty_i = (r == 3) || (r == 4) || (r == 5);
            if (r == 1 || r == 5) begin
                if (wb_we_o) smem[wb_adr_o] = merge(smem.exists(wb_adr_o) ? smem[wb_adr_o] : 32'h0, wb_dat_o, wb_sel_o);
                else         wb_dat_i = smem.exists(wb_adr_o) ? smem[wb_adr_o] : 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the script cycle by cycle using the protocol rules.
    task automatic model_run(input int scr[$], output int t, output int gaps, output logic err, output logic ok);
        int idx, waits, retries, r;
        bit done;
        idx = 0; t = 0; gaps = 0; waits = 0; retries = 0; done = 0; err = 1'b0; ok = 1'b0;
        while (!done) begin
            r = (idx < scr.size()) ? scr[idx] : 0;
            idx++; t++;
            case (r)
                0: begin waits++; if (waits == TIMEOUT) begin err = 1'b1; done = 1; end end
                1, 5: begin ok = 1'b1; done = 1; end
                2, 4: begin err = 1'b1; done = 1; end
                default: begin
                    if (retries < RETRY_MAX) begin retries++; gaps++; t++; waits = 0; end
                    else begin err = 1'b1; done = 1; end
                end
            endcase
        end
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] a, input logic [3:0] s,
                           input logic w, input logic [31:0] d, input bit ovl);
        int t_exp, g_exp, n, gaps, bad;
        logic e_exp, ok_exp;
        model_run(script, t_exp, g_exp, e_exp, ok_exp);
        resp_q = script;
        address = a; selection = s; write = w; data_wr = d; start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        chk({tag, ":start_bus"}, {active, wb_cyc_o, wb_stb_o, error}, 4'b1110);
        chk({tag, ":start_req"}, {wb_adr_o, wb_dat_o}, {a, d});
        chk({tag, ":start_ctl"}, {wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}, {w, s, 3'b000, 2'b00});
        n = 0; gaps = 0; bad = 0;
        while (active === 1'b1 && n < 300) begin
            if (ovl && n == 1) begin
                start = 1'b1; address = ~a; write = ~w; data_wr = ~d;
            end else if (ovl && n == 2) begin
                start = 1'b0; address = a; write = w; data_wr = d;
            end
            @(posedge wb_clk); #1;
            n++;
            if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b0) gaps++;
            if (wb_stb_o === 1'b1 && (wb_adr_o !== a || wb_we_o !== w || wb_sel_o !== s ||
                wb_dat_o !== d || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00)) bad++;
        end
        start = 1'b0;
        chk({tag, ":duration"}, n, t_exp);
        chk({tag, ":retry_gaps"}, gaps, g_exp);
        chk({tag, ":bus_hold"}, bad, 0);
        chk({tag, ":error"}, error, e_exp);
        chk({tag, ":idle_bus"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o}, 35'h0);
        if (ok_exp) begin
            if (w) mmem[a] = merge(mmem.exists(a) ? mmem[a] : 32'h0, d, s);
            else   exp_rd = mmem.exists(a) ? mmem[a] : 32'h0;
        end
        chk({tag, ":data_rd"}, data_rd, exp_rd);
        if (ovl) begin
            repeat (3) begin @(posedge wb_clk); #1; end
            chk({tag, ":no_relaunch"}, {wb_cyc_o, active}, 2'b00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic [31:0] ra;
        repeat (3) @(posedge wb_clk);
        #1;
        chk("reset:outputs", {wb_cyc_o, wb_stb_o, active, error, data_rd}, 36'h0);
        @(negedge wb_clk); wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        chk("post_reset:idle", {wb_cyc_o, active}, 2'b00);

        script = '{1};
        do_xfer("write", 32'h9000_0000, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0);
        script = '{1};
        do_xfer("readback", 32'h9000_0000, 4'hF, 1'b0, 32'h0, 1'b0);
        script = '{2};
        do_xfer("err_resp", 32'h9000_0000, 4'hF, 1'b0, 32'h0, 1'b0);
        script = '{3, 3, 1};
        do_xfer("retry2", 32'h9000_0004, 4'h3, 1'b1, 32'h1234_5678, 1'b0);
        script = '{3, 3, 3, 3, 3};
        do_xfer("retry_exh", 32'h9000_0004, 4'hF, 1'b0, 32'h0, 1'b0);
        script = '{4};
        do_xfer("prio_err", 32'h9000_0004, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        script = '{5};
        do_xfer("prio_ack", 32'h9000_0004, 4'hF, 1'b0, 32'h0, 1'b0);
        script.delete();
        do_xfer("timeout", 32'h9000_0008, 4'hF, 1'b0, 32'h0, 1'b0);
        script = '{0, 0, 0, 1};
        do_xfer("overlap", 32'h9000_0008, 4'hC, 1'b1, 32'hCAFE_F00D, 1'b1);

        // Reset in the middle of a silent transfer must drop the bus at once.
        resp_q.delete();
        address = 32'h9000_000C; selection = 4'hF; write = 1'b0; start = 1'b1;
        @(posedge wb_clk); #1; start = 1'b0;
        repeat (3) begin @(posedge wb_clk); #1; end
        chk("midreset:before", {wb_cyc_o, active}, 2'b11);
        #2 wb_rst = 1'b0;
        #1 chk("midreset:drop", {wb_cyc_o, wb_stb_o, active, error, data_rd}, 36'h0);
        exp_rd = 32'h0;
        @(negedge wb_clk); wb_rst = 1'b1;
        @(posedge wb_clk); #1;

        for (int i = 0; i < 25; i++) begin
            int nr;
            script.delete();
            nr = $urandom_range(0, 5);
            for (int k = 0; k < nr; k++) begin
                repeat ($urandom_range(0, 2)) script.push_back(0);
                script.push_back(3);
            end
            repeat ($urandom_range(0, 2)) script.push_back(0);
            script.push_back(($urandom_range(0, 9) < 7) ? 1 : 2);
            ra = 32'h9000_0000 + 32'($urandom_range(0, 3)) * 32'd4;
            do_xfer($sformatf("rand%0d", i), ra, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                    $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
